// File: rtl/reuleaux_seq_if.sv
// Circle-engine bus for the Reuleaux sequencer.
//   master : sequencer side. Drives start/centre/radius and receives finished plus pixel stream.
//   slave  : circle engine side.
interface reuleaux_seq_if;
  logic       circ_start;
  logic       circ_finished;
  logic [7:0] circ_cx;
  logic [7:0] circ_cy;
  logic [7:0] circ_radius;
  logic [7:0] circ_x;
  logic [6:0] circ_y;
  logic       circ_plot;

  modport master (
    output circ_start, circ_cx, circ_cy, circ_radius,
    input  circ_finished, circ_x, circ_y, circ_plot
  );

  modport slave (
    input  circ_start, circ_cx, circ_cy, circ_radius,
    output circ_finished, circ_x, circ_y, circ_plot
  );
endinterface

// File: rtl/reuleaux_seq.sv
// Reuleaux triangle sequencer: runs one circle engine three times (one arc per
// triangle corner, radius = side length) and windows each arc's pixels.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start / finished     level request from the top FSM / completion level
//   centre_x/y, diameter triangle centroid and side length
//   colour               pixel colour, latched with the request
//   circ                 circle engine bus (start/finished, centre, radius, pixels)
//   vga_x/y/colour/plot  plot port; x/y pass straight through from the engine
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | wait for start, latch geometry and colour
// LATCH  | corners now valid; pick first on-screen arc
// GAP    | engine start held low; corner/radius set up and held
// DRAW   | engine start high until it reports finished
// DONE   | finished high until start drops
module reuleaux_seq #(
  parameter int K_H3       = 37,
  parameter int K_2H3      = 74,
  parameter int FRAC       = 7,
  parameter int GAP_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [7:0]     centre_x,
  input  logic [7:0]     centre_y,
  input  logic [7:0]     diameter,
  input  logic [2:0]     colour,
  output logic           finished,
  reuleaux_seq_if.master circ,
  output logic [7:0]     vga_x,
  output logic [6:0]     vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);

  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP, S_DRAW, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cx_q, cx_d, cy_q, cy_d, dia_q, dia_d;
  logic [2:0]       col_q, col_d;
  logic [1:0]       arc_q, arc_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       ccx_q, ccx_d, ccy_q, ccy_d, crad_q, crad_d;

  // Corners are 10-bit two's complement; on-screen means bits [9:8] are zero.
  logic [7:0] hd;
  logic [9:0] off_a, off_b;
  logic [9:0] c1x, c2x, c1y, c3y;
  logic [2:0] valid;
  logic       first_found, nxt_found;
  logic [1:0] first_arc, nxt_arc, ld_idx;
  logic [7:0] ld_x, ld_y;
  logic       in_win;

  always_comb begin
    hd       = {1'b0, dia_q[7:1]};
    off_a    = 10'((16'(dia_q) * 16'(K_H3)) >> FRAC);
    off_b    = 10'((16'(dia_q) * 16'(K_2H3)) >> FRAC);
    c1x      = {2'b00, cx_q} + {2'b00, hd};
    c2x      = {2'b00, cx_q} - {2'b00, hd};
    c1y      = {2'b00, cy_q} + off_a;
    c3y      = {2'b00, cy_q} - off_b;
    valid[0] = (c1x[9:8] == 2'b00) && (c1y[9:8] == 2'b00);
    valid[1] = (c2x[9:8] == 2'b00) && (c1y[9:8] == 2'b00);
    valid[2] = (c3y[9:8] == 2'b00);
  end

  // Lowest valid arc overall, and lowest valid arc after the current one.
  always_comb begin
    first_found = 1'b0;
    first_arc   = 2'd0;
    nxt_found   = 1'b0;
    nxt_arc     = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (valid[i]) begin
        first_found = 1'b1;
        first_arc   = 2'(i);
      end
      if (valid[i] && (2'(i) > arc_q)) begin
        nxt_found = 1'b1;
        nxt_arc   = 2'(i);
      end
    end
  end

  always_comb begin
    ld_idx = (state_q == S_LATCH) ? first_arc : nxt_arc;
    case (ld_idx)
      2'd0:    begin ld_x = c1x[7:0]; ld_y = c1y[7:0]; end
      2'd1:    begin ld_x = c2x[7:0]; ld_y = c1y[7:0]; end
      default: begin ld_x = cx_q;     ld_y = c3y[7:0]; end
    endcase
  end

  // Each arc only contributes the part of its circle that bounds the triangle.
  always_comb begin
    case (arc_q)
      2'd0:    in_win = (circ.circ_x <= cx_q) && ({3'b000, circ.circ_y} <= c1y);
      2'd1:    in_win = (circ.circ_x >= cx_q) && ({3'b000, circ.circ_y} <= c1y);
      default: in_win = ({3'b000, circ.circ_y} >= c1y);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dia_d   = dia_q;
    col_d   = col_q;
    arc_d   = arc_q;
    gap_d   = gap_q;
    ccx_d   = ccx_q;
    ccy_d   = ccy_q;
    crad_d  = crad_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = centre_x;
          cy_d    = centre_y;
          dia_d   = diameter;
          col_d   = colour;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (first_found) begin
          arc_d   = first_arc;
          ccx_d   = ld_x;
          ccy_d   = ld_y;
          crad_d  = dia_q;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        // Leave only once the minimum gap has elapsed and the engine has
        // released its finished level from the previous arc.
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (!circ.circ_finished) begin
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (circ.circ_finished) begin
          if (nxt_found) begin
            arc_d   = nxt_arc;
            ccx_d   = ld_x;
            ccy_d   = ld_y;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      dia_q   <= '0;
      col_q   <= '0;
      arc_q   <= '0;
      gap_q   <= '0;
      ccx_q   <= '0;
      ccy_q   <= '0;
      crad_q  <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dia_q   <= dia_d;
      col_q   <= col_d;
      arc_q   <= arc_d;
      gap_q   <= gap_d;
      ccx_q   <= ccx_d;
      ccy_q   <= ccy_d;
      crad_q  <= crad_d;
    end
  end

  assign finished         = (state_q == S_DONE);
  assign circ.circ_start  = (state_q == S_DRAW);
  assign circ.circ_cx     = ccx_q;
  assign circ.circ_cy     = ccy_q;
  assign circ.circ_radius = crad_q;
  assign vga_x            = circ.circ_x;
  assign vga_y            = circ.circ_y;
  assign vga_colour       = col_q;
  assign vga_plot         = circ.circ_plot && (state_q == S_DRAW) && in_win;

endmodule

// File: doc/reuleaux_seq.md
Name: reuleaux_seq

Overview:
Sequencer that draws a Reuleaux triangle by running one circle engine three times, once per triangle corner, with radius equal to the diameter. It latches the request, computes the three corner centres, and drives the engine's start/finished level handshake with reset gaps between arcs. It passes engine pixels through to the VGA plot port and gates each pixel to that arc's window. It sits between the top-level FSM and the circle engine.

Parameters:
K_H3, 37, fixed-point approx of sqrt(3)/6 (corner y-offset = d*K_H3 >> FRAC)
K_2H3, 74, fixed-point approx of sqrt(3)/3 (apex y-offset = d*K_2H3 >> FRAC)
FRAC, 7, fraction bits of the K constants
GAP_CYCLES, 4, minimum cycles circ_start is held low before each arc (min 3)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  request level; held high until finished
centre_x  in  8  triangle centroid x
centre_y  in  8  triangle centroid y
diameter  in  8  side length d (= arc radius)
colour  in  3  pixel colour
finished  out  1  high when all arcs are done, until start drops
circ_start  out  1  circle engine start level
circ_finished  in  1  circle engine finished
circ_cx  out  8  engine centre x
circ_cy  out  8  engine centre y
circ_radius  out  8  engine radius
circ_x  in  8  engine vga_x
circ_y  in  7  engine vga_y
circ_plot  in  1  engine vga_plot
vga_x  out  8  = circ_x (combinational)
vga_y  out  7  = circ_y (combinational)
vga_colour  out  3  latched colour
vga_plot  out  1  gated plot strobe

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; finished=0, circ_start=0, vga_plot=0, circ_cx/cy/radius=0, vga_colour=0, arc index=0.
- States: IDLE -> LATCH -> GAP -> DRAW -> (GAP for next arc | DONE) -> IDLE.
- IDLE: when start=1, latch centre_x, centre_y, diameter, colour, then go to LATCH.
- LATCH (1 cycle): compute 10-bit signed corners. hd = d>>1; a = (d*K_H3)>>FRAC; b = (d*K_2H3)>>FRAC, using 16-bit products.
  - C1 = (cx+hd, cy+a); C2 = (cx-hd, cy+a); C3 = (cx, cy-b).
  - Arc n is valid iff both coordinates of Cn are in 0..255. Set arc index to the first valid arc. If no arc is valid, go to DONE.
- GAP: circ_start=0. circ_cx/cy = current corner and circ_radius=d, driven from GAP entry and held stable through DRAW. Leave after at least GAP_CYCLES cycles and only when circ_finished=0, then go to DRAW.
- DRAW: circ_start=1. When circ_finished=1, advance to the next valid arc and go to GAP, or go to DONE if none remain. Invalid arcs are skipped entirely; no circ_start pulse is issued for them.
- DONE: finished=1, circ_start=0. When start=0, go to IDLE and finished=0 on the next cycle.
- start dropping mid-operation is ignored; the sequence completes.
- vga_plot = circ_plot AND (state==DRAW) AND window(arc). Windows:
  - arc1 (centre C1): circ_x <= cx and circ_y <= C1.y.
  - arc2 (centre C2): circ_x >= cx and circ_y <= C2.y.
  - arc3 (centre C3): circ_y >= C1.y.
  - Comparisons are unsigned and zero-extended against the latched values.
- vga_x, vga_y, vga_plot have zero latency from engine outputs. Off-screen clipping is the engine's responsibility.

Test Plan:
- Nominal: centre (80,60), d=80, start held high. Corners must be C1=(120,83), C2=(40,83), C3=(80,14). Exactly three circ_start rising edges with circ_radius=80. finished=1 after the third circ_finished. Dropping start clears finished one cycle later.
- Window gating: during arc1, engine pixel (130,70) with circ_plot=1 gives vga_plot=0, and pixel (41,80) gives vga_plot=1. During arc3, pixel (80,90) gives 1 and (80,70) gives 0.
- Skip: centre (10,60), d=40. C2.x=-10, so only two arcs are drawn (C1 and C3), and circ_cx never equals 246.
- Gap/handshake: using a behavioural engine that holds circ_finished high for 2 cycles after start drops, circ_start stays low for at least 4 cycles and until circ_finished=0. circ_cx/cy/radius stay constant from GAP entry to DRAW exit.
- Reset mid-DRAW on arc 2: the next cycle gives circ_start=0, vga_plot=0, finished=0, state IDLE. A new start then redraws from arc1.
- Start glitch: start dropped during arc2 DRAW and raised again still completes all arcs. finished is asserted, then cleared only when start=0.
